// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - groups multiplier products into a wide sum with count and overflow
module prod_accum #(
    parameter int PW = 8,
    parameter int N  = 4,
    parameter int AW = 10,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_cnt,
    output logic          out_ovf
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic          accept;
    logic [AW:0]   sum_ext;
    logic [CW-1:0] cnt_nxt;
    logic          ovf_nxt;
    logic          end_group;

    // in_ready is gated by rst so nothing is taken during the reset cycle itself.
    assign in_ready  = (state == ST_ACC) & ~rst;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;

    // One extra bit captures the carry out of the accumulator; the flag is sticky per group.
    assign sum_ext   = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, in_prod};
    assign cnt_nxt   = cnt + 1'b1;
    assign ovf_nxt   = ovf | sum_ext[AW];
    assign end_group = in_last | (cnt_nxt == CW'(N));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= sum_ext[AW-1:0];
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (end_group) begin
                            out_sum <= sum_ext[AW-1:0];
                            out_cnt <= cnt_nxt;
                            out_ovf <= ovf_nxt;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Result registers are left alone so they hold until the next group completes.
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - scoreboard bench for prod_accum at AW=10 and AW=9
module tb_prod_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_prod = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [9:0] out_sum_a;
    logic [2:0] out_cnt_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [8:0] out_sum_b;
    logic [2:0] out_cnt_b;

    int checks = 0;
    int errors = 0;
    bit rnd_ready = 1'b0;

    typedef struct {
        int s10;
        int s9;
        int c;
        bit o10;
        bit o9;
    } exp_t;

    exp_t exp_q[$];
    int   grp_q[$];

    prod_accum #(.PW(8), .N(4), .AW(10), .CW(3)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a)
    );

    prod_accum #(.PW(8), .N(4), .AW(9), .CW(3)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a group is a list of products; its result is plain arithmetic over that list.
    task automatic model_accept(input int p, input bit last);
        exp_t e;
        int   total;
        grp_q.push_back(p);
        if (last || grp_q.size() == 4) begin
            total = 0;
            e.o10 = 1'b0;
            e.o9  = 1'b0;
            foreach (grp_q[i]) begin
                total += grp_q[i];
                if (total > 1023) e.o10 = 1'b1;
                if (total > 511)  e.o9  = 1'b1;
            end
            e.s10 = total % 1024;
            e.s9  = total % 512;
            e.c   = grp_q.size();
            exp_q.push_back(e);
            grp_q.delete();
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input int p, input bit last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_prod  = p[7:0];
        in_last  = last;
        #1;
        while (!in_ready_a) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", guard, 0);
                break;
            end
        end
        if (guard <= 200) model_accept(p, last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
    end

    // Monitor: compares on every emit and checks result stability under backpressure.
    bit         hold = 1'b0;
    logic [9:0] h_sum_a;
    logic [8:0] h_sum_b;
    logic [2:0] h_cnt;
    logic       h_ovf_b;

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid_a, 1);
                chk("hold_sum_a", out_sum_a, h_sum_a);
                chk("hold_sum_b", out_sum_b, h_sum_b);
                chk("hold_cnt", out_cnt_a, h_cnt);
                chk("hold_ovf_b", out_ovf_b, h_ovf_b);
            end
            if (out_valid_a) chk("in_ready_in_done", in_ready_a, 0);
            if (out_valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum_a", out_sum_a, e.s10);
                    chk("cnt_a", out_cnt_a, e.c);
                    chk("ovf_a", out_ovf_a, e.o10);
                    chk("valid_b", out_valid_b, 1);
                    chk("sum_b", out_sum_b, e.s9);
                    chk("cnt_b", out_cnt_b, e.c);
                    chk("ovf_b", out_ovf_b, e.o9);
                end
            end
            hold    = out_valid_a && !out_ready;
            h_sum_a = out_sum_a;
            h_sum_b = out_sum_b;
            h_cnt   = out_cnt_a;
            h_ovf_b = out_ovf_b;
        end
    end

    initial begin
        int len;
        int guard;

        // Reset held two cycles with a product offered: nothing may be taken.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 8'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_sum", out_sum_a, 0);
        chk("rst_out_cnt", out_cnt_a, 0);
        chk("rst_out_ovf", out_ovf_a, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("release_in_ready", in_ready_a, 1);
        @(negedge clk);

        // Full group on back-to-back cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(225, 1'b0);
        #1;
        chk("full_latency_valid", out_valid_a, 1);
        chk("full_in_ready_done", in_ready_a, 0);
        @(negedge clk);
        #1;
        chk("full_in_ready_after", in_ready_a, 1);
        chk("full_valid_after", out_valid_a, 0);
        @(negedge clk);

        // Early end with an idle gap.
        send(10, 1'b0);
        @(negedge clk);
        send(20, 1'b1);
        @(negedge clk);

        // Backpressure with a product waiting.
        out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        send(4, 1'b0);
        in_valid = 1'b1;
        in_prod  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_out_valid", out_valid_a, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(99, 1'b1);
        @(negedge clk);

        // Overflow on the narrow instance, then a clean group.
        for (int i = 0; i < 4; i++) send(225, 1'b0);
        for (int i = 0; i < 4; i++) send(1, 1'b0);
        @(negedge clk);

        // Reset mid-group discards the partial sum.
        send(50, 1'b0);
        send(60, 1'b0);
        rst = 1'b1;
        grp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(5, 1'b1);
        @(negedge clk);

        // Randomized groups with gaps and random backpressure.
        rnd_ready = 1'b1;
        for (int g = 0; g < 200; g++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(($urandom_range(0, 3) == 0) ? 225 : $urandom_range(0, 255),
                     (k == len - 1) && (len < 4 || $urandom_range(0, 1) == 1));
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
# prod_accum

Sequential accumulator that sits directly downstream of the 4x4 Wallace-tree multiplier. It takes one 8-bit product per handshake and sums a group of products into a wider accumulator. A group ends after N products or on `in_last`, whichever comes first. The block then presents the group sum with a count and an overflow flag on a valid/ready output, forming the dot-product stage of the multiplier datapath.

## Interface
- `PW`, 8, product width (multiplier `prod` width)
- `N`, 4, maximum products per group
- `AW`, 10, accumulator/result width; must be ≥ PW
- `CW`, 3, count width; must hold N

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  product available
- `in_ready`  out  1  block accepts product this cycle
- `in_prod`  in  PW  unsigned product from multiplier
- `in_last`  in  1  qualifies `in_prod`: final product of group
- `out_valid`  out  1  group result available
- `out_ready`  in  1  sink accepts result
- `out_sum`  out  AW  group sum modulo 2^AW
- `out_cnt`  out  CW  number of products in group (1..N)
- `out_ovf`  out  1  sum exceeded 2^AW−1 at any point in group

## Operation
- Reset is synchronous and active-high: one clock, `clk`; reset `rst`.
- Accept = `in_valid & in_ready`. Emit = `out_valid & out_ready`.
- FSM, two states:
  - ACC: `in_ready=1`, `out_valid=0`.
    - On accept: `acc <= (acc + in_prod) mod 2^AW`; `cnt <= cnt+1`.
    - Overflow flag set if the AW+1-bit sum has bit AW set; the flag is sticky within the group.
    - If accept with (`in_last`=1 or `cnt+1==N`): load `out_sum`, `out_cnt`, `out_ovf` from the updated values, go to DONE.
  - DONE: `in_ready=0`, `out_valid=1`, outputs held stable.
    - On emit: `acc`, `cnt` and the overflow flag clear to 0; go to ACC.
    - No product accepted in the emit cycle.
- `in_valid` with `in_ready=0` is ignored; the source must hold it.
- `in_prod` and `in_last` are don't-care when not accepted.
- Arithmetic is unsigned; no saturation, the sum wraps modulo 2^AW.
- With defaults, max 4×225=900 < 1024, so `out_ovf` stays 0 for 4x4 products.
- `in_last` on the first product is legal: `out_cnt=1`.
- Zero-length groups do not exist.
- Reset during ACC mid-group discards partial `acc`/`cnt`. Reset during DONE drops the pending result.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state ACC
  - `acc=0`, `cnt=0`
  - `out_valid=0`, `out_sum=0`, `out_cnt=0`, `out_ovf=0`
- `in_ready` = (state==ACC) & ~`rst`. It is 0 while `rst` is high and 1 the first cycle after release.
- Latency: `out_valid` rises the cycle after the final product is accepted.
- Throughput with `out_ready` tied high: a group of k products takes k+1 cycles.
- `out_sum`, `out_cnt` and `out_ovf` change only on the transition into DONE or on reset. They remain stable while `out_valid=1` and `out_ready=0`.
- Gaps in `in_valid` within a group are allowed; partial state holds.

## Test plan
- Reset: assert `rst` 2 cycles with `in_valid=1` → no accept; all outputs 0; `in_ready=1` the first cycle after release.
- Full group: 225,225,225,225 on consecutive cycles with `out_ready=1` →
  - `out_valid=1` one cycle after the 4th accept, with `out_sum=900`, `out_cnt=4`, `out_ovf=0`.
  - `in_ready=0` that cycle and 1 the next.
- Early end with gap: 10, idle cycle, 20 with `in_last=1` → `out_sum=30`, `out_cnt=2`.
- Backpressure: after a group of 1,2,3,4 (sum 10), hold `out_ready=0` for 5 cycles while driving `in_valid=1`, `in_prod=99` →
  - `out_valid`, `out_sum=10`, `out_cnt=4` held stable; `in_ready=0`; nothing accepted.
  - Release `out_ready` → emit, then 99 starts a new group.
- Overflow with AW=9 instance: 225×4 → `out_sum=388`, `out_ovf=1`. Next group 1,1,1,1 → `out_sum=4`, `out_ovf=0`.
- Reset mid-group: accept 50,60, pulse `rst` one cycle, then 5 with `in_last=1` → `out_sum=5`, `out_cnt=1`.
